// File: rtl/control_sequencer.sv
// control_sequencer: microcoded fetch/decode/execute control FSM with memory-timeout detection.
// Inputs : clk, rst_n (async, active-low), start (run request), mem_ready (read data valid),
//          ir_in (opcode from instruction register).
// Outputs: LDAR/mem_rd/LDDR/LDIR/pc_inc strobes, counter_out (micro-address, 0 = no override),
//          busy, halted, mem_err (sticky timeout), state (debug encoding).
module control_sequencer #(
  parameter int                         INSTRUCTION_LEN = 6,
  parameter int                         TIMEOUT         = 255,
  parameter logic [INSTRUCTION_LEN-1:0] HALT_OP         = 'h3F
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       mem_ready,
  input  logic [INSTRUCTION_LEN-1:0] ir_in,
  output logic                       LDAR,
  output logic                       mem_rd,
  output logic                       LDDR,
  output logic                       LDIR,
  output logic                       pc_inc,
  output logic [INSTRUCTION_LEN-1:0] counter_out,
  output logic                       busy,
  output logic                       halted,
  output logic                       mem_err,
  output logic [2:0]                 state
);
  typedef enum logic [2:0] {
    IDLE, FETCH_ADDR, FETCH_WAIT, FETCH_LOAD, LOAD_IR, DECODE, EXEC, HALT
  } state_e;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);
  state_e                     state_q, state_d;
  logic [INSTRUCTION_LEN-1:0] op_q, op_d;
  logic [1:0]                 step_q, step_d;
  logic [WW-1:0]              wait_q, wait_d;
  logic                       err_d;
  assign state = state_q;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    step_d  = step_q;
    wait_d  = wait_q;
    err_d   = mem_err;
    case (state_q)
      IDLE:       state_d = start ? FETCH_ADDR : IDLE;
      FETCH_ADDR: begin
        state_d = FETCH_WAIT;
        wait_d  = '0;
      end
      // ready wins over timeout in the final wait cycle
      FETCH_WAIT: begin
        if (mem_ready) state_d = FETCH_LOAD;
        else if (wait_q == LAST) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else wait_d = wait_q + 1'b1;
      end
      FETCH_LOAD: state_d = LOAD_IR;
      LOAD_IR:    state_d = DECODE;
      DECODE: begin
        op_d    = ir_in;
        step_d  = '0;
        state_d = (ir_in == HALT_OP) ? HALT : EXEC;
      end
      // run length is op[1:0]+1, so the last step index equals op[1:0]
      EXEC: begin
        if (step_q == op_q[1:0]) state_d = FETCH_ADDR;
        else step_d = step_q + 1'b1;
      end
      HALT: begin
        if (start) begin
          state_d = FETCH_ADDR;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs are registered from the next-state values so they align with state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      step_q      <= '0;
      wait_q      <= '0;
      mem_err     <= 1'b0;
      LDAR        <= 1'b0;
      mem_rd      <= 1'b0;
      LDDR        <= 1'b0;
      LDIR        <= 1'b0;
      pc_inc      <= 1'b0;
      counter_out <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      step_q      <= step_d;
      wait_q      <= wait_d;
      mem_err     <= err_d;
      LDAR        <= state_d == FETCH_ADDR;
      mem_rd      <= state_d == FETCH_WAIT;
      LDDR        <= state_d == FETCH_LOAD;
      LDIR        <= state_d == LOAD_IR;
      pc_inc      <= state_d == LOAD_IR;
      counter_out <= (state_d == EXEC && step_d != '0) ? op_d + INSTRUCTION_LEN'(step_d) : '0;
      busy        <= state_d != IDLE && state_d != HALT;
      halted      <= state_d == HALT;
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer.
module tb_control_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] ir_in = '0;
  logic       LDAR, mem_rd, LDDR, LDIR, pc_inc, busy, halted, mem_err;
  logic [5:0] counter_out;
  logic [2:0] state;
  int         checks = 0;
  int         fails = 0;
  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_ready(mem_ready), .ir_in(ir_in),
    .LDAR(LDAR), .mem_rd(mem_rd), .LDDR(LDDR), .LDIR(LDIR), .pc_inc(pc_inc),
    .counter_out(counter_out), .busy(busy), .halted(halted), .mem_err(mem_err), .state(state)
  );
  always #5 clk = ~clk;
  wire [16:0] obs = {state, LDAR, mem_rd, LDDR, LDIR, pc_inc, counter_out, busy, halted, mem_err};
  function automatic logic [16:0] ev(int s, int c, logic e);
    logic [2:0] st;
    st = 3'(s);
    ev = {st, st == 3'd1, st == 3'd2, st == 3'd3, st == 3'd4, st == 3'd4, 6'(c),
          st != 3'd0 && st != 3'd7, st == 3'd7, e};
  endfunction
  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; ir_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 17'h0) begin fails++; $display("FAIL reset_state got %h exp %h", obs, 17'h0); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== ev(0, 0, 0)) begin fails++; $display("FAIL idle_no_start got %h exp %h", obs, ev(0, 0, 0)); end
  endtask
  task automatic test_basic();
    int st[8] = '{1, 2, 3, 4, 5, 6, 6, 1};
    int cn[8] = '{0, 0, 0, 0, 0, 0, 6, 0};
    do_reset();
    ir_in = 6'h05; mem_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      checks++;
      if (obs !== ev(st[i], cn[i], 0)) begin fails++; $display("FAIL basic cyc %0d got %h exp %h", i, obs, ev(st[i], cn[i], 0)); end
    end
  endtask
  task automatic test_start_held();
    int st[8] = '{1, 2, 3, 4, 5, 6, 6, 1};
    int cn[8] = '{0, 0, 0, 0, 0, 0, 6, 0};
    do_reset();
    ir_in = 6'h05; mem_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== ev(st[i], cn[i], 0)) begin fails++; $display("FAIL start_held cyc %0d got %h exp %h", i, obs, ev(st[i], cn[i], 0)); end
    end
    start = 1'b0;
  endtask
  task automatic test_wrap();
    int st[9] = '{1, 2, 3, 4, 5, 6, 6, 6, 1};
    int cn[9] = '{0, 0, 0, 0, 0, 0, 'h3F, 0, 0};
    do_reset();
    ir_in = 6'h3E; mem_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      checks++;
      if (obs !== ev(st[i], cn[i], 0)) begin fails++; $display("FAIL wrap cyc %0d got %h exp %h", i, obs, ev(st[i], cn[i], 0)); end
    end
  endtask
  task automatic test_halt();
    int st[7] = '{1, 2, 3, 4, 5, 7, 7};
    do_reset();
    ir_in = 6'h3F; mem_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      checks++;
      if (obs !== ev(st[i], 0, 0)) begin fails++; $display("FAIL halt cyc %0d got %h exp %h", i, obs, ev(st[i], 0, 0)); end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (obs !== ev(1, 0, 0)) begin fails++; $display("FAIL halt_restart got %h exp %h", obs, ev(1, 0, 0)); end
  endtask
  task automatic test_timeout();
    int rd = 0;
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_rd) rd++;
      if (state == 3'd7) break;
    end
    checks++;
    if (rd !== 255) begin fails++; $display("FAIL timeout_rd_cycles got %0d exp 255", rd); end
    checks++;
    if (obs !== ev(7, 0, 1)) begin fails++; $display("FAIL timeout_halt got %h exp %h", obs, ev(7, 0, 1)); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (obs !== ev(1, 0, 0)) begin fails++; $display("FAIL timeout_restart got %h exp %h", obs, ev(1, 0, 0)); end
  endtask
  task automatic test_ready_last();
    int rd = 0;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (mem_rd) rd++;
    end
    checks++;
    if (rd !== 255) begin fails++; $display("FAIL ready_last_rd_cycles got %0d exp 255", rd); end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== ev(3, 0, 0)) begin fails++; $display("FAIL ready_last_load got %h exp %h", obs, ev(3, 0, 0)); end
  endtask
  task automatic test_async_reset();
    int st[8] = '{1, 2, 3, 4, 5, 6, 6, 6};
    int cn[8] = '{0, 0, 0, 0, 0, 0, 8, 9};
    do_reset();
    ir_in = 6'h07; mem_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      checks++;
      if (obs !== ev(st[i], cn[i], 0)) begin fails++; $display("FAIL exec07 cyc %0d got %h exp %h", i, obs, ev(st[i], cn[i], 0)); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 17'h0) begin fails++; $display("FAIL async_reset got %h exp %h", obs, 17'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== ev(0, 0, 0)) begin fails++; $display("FAIL post_reset_idle got %h exp %h", obs, ev(0, 0, 0)); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_start_held();
    test_wrap();
    test_halt();
    test_timeout();
    test_ready_last();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
